axil_lite_master: RTL and testbench

- AXI4-Lite master (initiator) that turns a simple one-beat command/response interface into AXI4-Lite write and read transactions.
- Drives the control registers of the stream/memory block from on-chip sequencers, replacing bench-driven register pokes.
- One transaction outstanding at a time.
- Counts error responses for diagnostics.

---
 rtl/axil_lite_master_if.sv | 57 +++++
 rtl/axil_lite_master.sv | 132 +++++++++++++
 tb/tb_axil_lite_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_lite_master_if.sv
// Bundle for axil_lite_master: command/response channel, AXI4-Lite bus and error counter.
// The master modport is the initiator's view; slave is the view of everything around it.
interface axil_lite_master_if #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ERRCNT_W = 8
) ();
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_W-1:0]     cmd_addr;
   logic [DATA_W-1:0]     cmd_wdata;
   logic [DATA_W/8-1:0]   cmd_wstrb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [DATA_W-1:0]     rsp_rdata;
   logic [1:0]            rsp_resp;
   logic [ERRCNT_W-1:0]   err_cnt;

   logic [ADDR_W-1:0]     awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_W-1:0]     araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_cnt,
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_cnt,
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready
   );
endinterface

// File: rtl/axil_lite_master.sv
// AXI4-Lite initiator: one command in, one AXI4-Lite transaction out, one response back.
// Single transaction outstanding; non-OKAY responses are counted in a saturating counter.
module axil_lite_master #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ERRCNT_W = 8
) (
   input logic                m_axi_aclk,
   input logic                m_axi_aresetn,
   axil_lite_master_if.master bus
);
   localparam int unsigned StrbW = DATA_W / 8;

   typedef enum logic [2:0] {StIdle, StWr, StWrB, StRdAr, StRdR, StRsp} state_e;

   state_e state_q, state_d;

   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [StrbW-1:0]    wstrb_q;
   logic                aw_done_q, w_done_q;
   logic                rsp_write_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic [1:0]          rsp_resp_q;
   logic [ERRCNT_W-1:0] err_cnt_q;

   logic       cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
   logic       rsp_latch;
   logic [1:0] new_resp;

   assign cmd_hs    = bus.cmd_valid && (state_q == StIdle);
   assign aw_hs     = bus.awvalid && bus.awready;
   assign w_hs      = bus.wvalid && bus.wready;
   assign b_hs      = bus.bready && bus.bvalid;
   assign ar_hs     = bus.arvalid && bus.arready;
   assign r_hs      = bus.rready && bus.rvalid;
   assign rsp_hs    = bus.rsp_valid && bus.rsp_ready;
   assign rsp_latch = b_hs || r_hs;
   assign new_resp  = b_hs ? bus.bresp : bus.rresp;

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cmd_hs) state_d = bus.cmd_write ? StWr : StRdAr;
         // Each channel may finish in an earlier cycle or in this one.
         StWr:    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWrB;
         StWrB:   if (b_hs) state_d = StRsp;
         StRdAr:  if (ar_hs) state_d = StRdR;
         StRdR:   if (r_hs) state_d = StRsp;
         StRsp:   if (rsp_hs) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.cmd_ready = 1'b0;
      bus.awvalid   = 1'b0;
      bus.wvalid    = 1'b0;
      bus.bready    = 1'b0;
      bus.arvalid   = 1'b0;
      bus.rready    = 1'b0;
      bus.rsp_valid = 1'b0;
      unique case (state_q)
         StIdle: bus.cmd_ready = 1'b1;
         StWr: begin
            bus.awvalid = !aw_done_q;
            bus.wvalid  = !w_done_q;
         end
         StWrB:   bus.bready    = 1'b1;
         StRdAr:  bus.arvalid   = 1'b1;
         StRdR:   bus.rready    = 1'b1;
         StRsp:   bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (cmd_hs) begin
            addr_q    <= bus.cmd_addr;
            wdata_q   <= bus.cmd_wdata;
            wstrb_q   <= bus.cmd_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end
         if (aw_hs) aw_done_q <= 1'b1;
         if (w_hs)  w_done_q  <= 1'b1;
         if (b_hs) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= bus.bresp;
         end
         if (r_hs) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= bus.rdata;
            rsp_resp_q  <= bus.rresp;
         end
         if (rsp_latch && (new_resp != 2'b00) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
         end
      end
   end

   assign bus.awaddr    = addr_q;
   assign bus.araddr    = addr_q;
   assign bus.awprot    = 3'b000;
   assign bus.arprot    = 3'b000;
   assign bus.wdata     = wdata_q;
   assign bus.wstrb     = wstrb_q;
   assign bus.rsp_write = rsp_write_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_resp  = rsp_resp_q;
   assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_axil_lite_master.sv
// Bench for axil_lite_master: scripted AXI4-Lite slave with per-channel delays and a
// response scoreboard; inputs driven and outputs sampled on the falling edge.
module tb_axil_lite_master;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   exp_err = 0;

   typedef struct packed {
      logic        wr;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } rsp_t;

   rsp_t sb_q[$];

   always #5 clk = ~clk;

   axil_lite_master_if #(.ADDR_W(32), .DATA_W(32), .ERRCNT_W(8)) bus ();

   axil_lite_master #(.ADDR_W(32), .DATA_W(32), .ERRCNT_W(8)) dut (
      .m_axi_aclk   (clk),
      .m_axi_aresetn(rst_n),
      .bus          (bus)
   );

   task automatic clear_slave();
      bus.awready   = 1'b0;
      bus.wready    = 1'b0;
      bus.bvalid    = 1'b0;
      bus.bresp     = 2'b00;
      bus.arready   = 1'b0;
      bus.rvalid    = 1'b0;
      bus.rdata     = '0;
      bus.rresp     = 2'b00;
      bus.rsp_ready = 1'b0;
   endtask

   // Called at a falling edge with the DUT idle; returns at the falling edge after RSP handshake.
   task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] resp, input logic [31:0] rd,
                         input int aw_dly, input int w_dly, input int ar_dly, input int r_dly,
                         input int rsp_dly, input bit spur, input bit hold);
      int   aw_seen = 0, w_seen = 0, ar_seen = 0, r_seen = 0, rsp_seen = 0;
      int   b_hs = 0, rsp_cyc = -1, exp_lat;
      bit   done = 1'b0;
      rsp_t exp;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = data;
      bus.cmd_wstrb = strb;
      bus.cmd_valid = 1'b1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept: cmd_ready=%b required 1", bus.cmd_ready);
      end
      exp.wr    = wr;
      exp.rdata = wr ? 32'h0 : rd;
      exp.resp  = resp;
      sb_q.push_back(exp);
      if (resp != 2'b00 && exp_err < 255) exp_err++;
      exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) : 3 + ar_dly + r_dly;
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            bus.cmd_valid = hold;
            bus.cmd_write = ~wr;
            bus.cmd_addr  = ~addr;
            bus.cmd_wdata = ~data;
         end
         bus.awready = bus.awvalid && (aw_seen == aw_dly);
         if (bus.awvalid) begin
            aw_seen++;
            checks++;
            if (bus.awaddr !== addr || bus.awprot !== 3'b000) begin
               errors++;
               $display("FAIL awaddr: got %h/%b required %h/000", bus.awaddr, bus.awprot, addr);
            end
         end
         bus.wready = bus.wvalid && (w_seen == w_dly);
         if (bus.wvalid) begin
            w_seen++;
            checks++;
            if ({bus.wdata, bus.wstrb} !== {data, strb}) begin
               errors++;
               $display("FAIL wdata: got %h/%h required %h/%h", bus.wdata, bus.wstrb, data, strb);
            end
         end
         bus.arready = bus.arvalid && (ar_seen == ar_dly);
         if (bus.arvalid) begin
            ar_seen++;
            checks++;
            if (bus.araddr !== addr || bus.arprot !== 3'b000) begin
               errors++;
               $display("FAIL araddr: got %h/%b required %h/000", bus.araddr, bus.arprot, addr);
            end
         end
         bus.bvalid = bus.bready || spur;
         bus.bresp  = bus.bready ? resp : 2'b11;
         if (bus.bready && bus.bvalid) b_hs++;
         bus.rvalid = (bus.rready && r_seen == r_dly) || (spur && !bus.rready);
         bus.rdata  = bus.rready ? rd : 32'hbad0_bad0;
         bus.rresp  = bus.rready ? resp : 2'b10;
         if (bus.rready) r_seen++;
         if (bus.rsp_valid) begin
            if (rsp_cyc < 0) rsp_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_fields: response with empty scoreboard");
            end else if ({bus.rsp_write, bus.rsp_rdata, bus.rsp_resp} !== sb_q[0]) begin
               errors++;
               $display("FAIL rsp_fields: got w=%b d=%h r=%b required w=%b d=%h r=%b",
                        bus.rsp_write, bus.rsp_rdata, bus.rsp_resp,
                        sb_q[0].wr, sb_q[0].rdata, sb_q[0].resp);
            end
            checks++;
            if (bus.cmd_ready !== 1'b0) begin
               errors++;
               $display("FAIL cmd_ready_in_rsp: got %b required 0", bus.cmd_ready);
            end
            bus.rsp_ready = (rsp_seen == rsp_dly);
            rsp_seen++;
            if (bus.rsp_ready) begin
               void'(sb_q.pop_front());
               done = 1'b1;
            end
         end else begin
            bus.rsp_ready = 1'b0;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL timeout: no response handshake within 60 cycles, required one");
      end
      @(negedge clk);
      clear_slave();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL back_to_idle: rsp_valid=%b cmd_ready=%b required 0/1",
                  bus.rsp_valid, bus.cmd_ready);
      end
      checks++;
      if (rsp_cyc !== exp_lat) begin
         errors++;
         $display("FAIL latency: rsp_valid at cycle %0d required %0d", rsp_cyc, exp_lat);
      end
      checks++;
      if (bus.err_cnt !== 8'(exp_err)) begin
         errors++;
         $display("FAIL err_cnt: got %0d required %0d", bus.err_cnt, exp_err);
      end
      if (wr) begin
         checks++;
         if (aw_seen !== aw_dly + 1 || w_seen !== w_dly + 1 || b_hs !== 1) begin
            errors++;
            $display("FAIL wr_valids: aw=%0d w=%0d b_hs=%0d required %0d %0d 1",
                     aw_seen, w_seen, b_hs, aw_dly + 1, w_dly + 1);
         end
      end else begin
         checks++;
         if (ar_seen !== ar_dly + 1 || r_seen !== r_dly + 1) begin
            errors++;
            $display("FAIL rd_valids: ar=%0d rready=%0d required %0d %0d",
                     ar_seen, r_seen, ar_dly + 1, r_dly + 1);
         end
      end
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid} !== 6'b0
          || bus.cmd_ready !== 1'b1 || bus.err_cnt !== 8'h00) begin
         errors++;
         $display("FAIL %s: valids/readys=%b cmd_ready=%b err_cnt=%0d required 000000/1/0", name,
                  {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid},
                  bus.cmd_ready, bus.err_cnt);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_wstrb = '0;
      clear_slave();
      repeat (2) @(negedge clk);
      check_quiet("reset_ctrl");
      checks++;
      if ({bus.awaddr, bus.wdata, bus.wstrb, bus.rsp_rdata, bus.rsp_resp} !== '0) begin
         errors++;
         $display("FAIL reset_regs: awaddr=%h wdata=%h rdata=%h resp=%b required all 0",
                  bus.awaddr, bus.wdata, bus.rsp_rdata, bus.rsp_resp);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write_zero_wait();
      do_txn(1'b1, 32'h0, 32'h1, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      do_txn(1'b1, 32'h4, 32'h4, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_write_late_wready();
      do_txn(1'b1, 32'h0, 32'h2, 4'h5, 2'b00, 32'h0, 0, 2, 0, 0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_read_delayed();
      do_txn(1'b0, 32'h4, 32'h0, 4'h0, 2'b00, 32'hFFFE_0001, 0, 0, 1, 2, 0, 1'b1, 1'b0);
   endtask

   task automatic test_error_count();
      do_txn(1'b1, 32'h8, 32'h3, 4'hF, 2'b10, 32'h0, 1, 0, 0, 0, 0, 1'b0, 1'b0);
      do_txn(1'b0, 32'hC, 32'h0, 4'h0, 2'b11, 32'h1234_5678, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 253; i++) begin
         do_txn(1'b1, 32'h10, 32'(i), 4'h1, 2'b10, 32'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      end
      do_txn(1'b0, 32'h14, 32'h0, 4'h0, 2'b01, 32'h0000_00AA, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (bus.err_cnt !== 8'hFF) begin
         errors++;
         $display("FAIL err_saturate: got %0d required 255", bus.err_cnt);
      end
   endtask

   task automatic test_back_to_back();
      do_txn(1'b0, 32'h4, 32'h0, 4'h0, 2'b00, 32'hCAFE_F00D, 0, 0, 0, 1, 5, 1'b0, 1'b1);
      do_txn(1'b1, 32'h18, 32'h55AA_55AA, 4'h3, 2'b00, 32'h0, 1, 1, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h20;
      bus.cmd_wdata = 32'h7777_0000;
      bus.cmd_wstrb = 4'hF;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      checks++;
      if (bus.awvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_write_awvalid: got %b required 1", bus.awvalid);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_err = 0;
      check_quiet("reset_mid_write");
      do_txn(1'b1, 32'h24, 32'h0BAD_CAFE, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_zero_wait();
      test_write_late_wready();
      test_read_delayed();
      test_error_count();
      test_back_to_back();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
